// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and sizing helpers for the instruction fetch stage.
//   fetch_entry_t : one queued instruction together with its word address
//   cntWidth()    : width needed to hold a count in the range 0..depth
package fetch_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int FETCH_DEPTH = 4;

    // A count of 0..depth inclusive needs one more code than a pointer does.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if
// Bundles the fetch stage's instruction-memory and decode/redirect signals.
//   master : the fetch unit (drives memory requests and the decode-side head)
//   slave  : the environment (memory, execute redirect, decode)
// Signals:
//   o_imem_req_valid / i_imem_req_ready / o_imem_addr : request handshake
//   i_imem_rsp_valid / i_imem_rdata                   : in-order responses
//   i_redirect_valid / i_redirect_pc                  : flush and restart
//   o_fetch_valid / o_fetch_instr / o_fetch_pc / i_dec_ready : decode handshake
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN
) ();

    logic            o_imem_req_valid;
    logic            i_imem_req_ready;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_rsp_valid;
    logic [XLEN-1:0] i_imem_rdata;
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_fetch_valid;
    logic [XLEN-1:0] o_fetch_instr;
    logic [XLEN-1:0] o_fetch_pc;
    logic            i_dec_ready;

    modport master (
        output o_imem_req_valid, o_imem_addr,
        output o_fetch_valid, o_fetch_instr, o_fetch_pc,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rdata,
        input  i_redirect_valid, i_redirect_pc, i_dec_ready
    );

    modport slave (
        input  o_imem_req_valid, o_imem_addr,
        input  o_fetch_valid, o_fetch_instr, o_fetch_pc,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rdata,
        output i_redirect_valid, i_redirect_pc, i_dec_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous FIFO of fetch_entry_t with flush.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i, pushData_i : write an entry at the tail
//   pop_i          : retire the head entry (ignored while empty)
//   flush_i        : drop all entries; wins over push and pop
//   headData_o     : current head entry
//   count_o, full_o, empty_o : occupancy
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              push_i,
    input  fetch_entry_t                      pushData_i,
    input  logic                              pop_i,
    input  logic                              flush_i,
    output fetch_entry_t                      headData_o,
    output logic [$clog2(DEPTH + 1)-1:0]      count_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam int CNT_W = cntWidth(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             doPop;

    // Popping an empty queue would corrupt the pointers, so it is ignored.
    assign doPop = pop_i && (count_q != '0);

    // Pointers are power-of-two sized, so natural overflow gives the wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (doPop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push_i && !doPop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_i && doPop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem[tail_q] <= pushData_i;
        end
    end

    assign headData_o = mem[head_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == DEPTH_C);
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Pipelined instruction fetch stage. Issues word-addressed requests to a
// variable-latency in-order memory, queues responses with their PCs and hands
// them to decode. A redirect flushes the queue and marks every in-flight
// response as stale so it is silently dropped on return.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : fetch_if master (memory request/response, redirect, decode)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     i_clk,
    input  logic     i_rst,
    fetch_if.master  bus
);

    localparam int CNT_W = cntWidth(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

    logic [XLEN-1:0]  reqPc_q;
    logic [XLEN-1:0]  reqPc_d;
    logic [XLEN-1:0]  rspPc_q;
    logic [XLEN-1:0]  rspPc_d;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] stale_q;
    logic [CNT_W-1:0] stale_d;

    logic [CNT_W-1:0] fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W:0]   creditsUsed;
    logic             redirect;
    logic             reqFire;
    logic             rspValid;
    logic             rspAccept;
    logic             pop;
    fetch_entry_t     pushEntry;
    fetch_entry_t     headEntry;

    assign redirect = bus.i_redirect_valid;
    assign rspValid = bus.i_imem_rsp_valid;

    // Every queued entry plus every in-flight request holds one queue slot,
    // which is what guarantees a response always finds room.
    assign creditsUsed          = {1'b0, fifoCount} + {1'b0, outstanding_q};
    assign bus.o_imem_req_valid = !redirect && (creditsUsed < DEPTH_C);
    assign bus.o_imem_addr      = reqPc_q;
    assign reqFire              = bus.o_imem_req_valid && bus.i_imem_req_ready;

    // A response is kept only when nothing older than it is still stale.
    assign rspAccept = rspValid && (stale_q == '0) && !redirect;

    assign bus.o_fetch_valid = !fifoEmpty && !redirect;
    assign bus.o_fetch_instr = headEntry.instr;
    assign bus.o_fetch_pc    = headEntry.pc;
    assign pop               = bus.o_fetch_valid && bus.i_dec_ready;

    assign pushEntry.pc    = rspPc_q;
    assign pushEntry.instr = bus.i_imem_rdata;

    // Next-state for PCs and credit/stale accounting. On a redirect no
    // request fires, so outstanding_d already equals "in flight minus the
    // response arriving now", which is exactly what must become stale.
    always_comb begin
        reqPc_d       = reqPc_q;
        rspPc_d       = rspPc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;
        if (reqFire) begin
            reqPc_d       = reqPc_q + XLEN'(1);
            outstanding_d = outstanding_q + CNT_W'(1);
        end
        if (rspValid) begin
            outstanding_d = outstanding_d - CNT_W'(1);
        end
        if (redirect) begin
            reqPc_d = bus.i_redirect_pc;
            rspPc_d = bus.i_redirect_pc;
            stale_d = outstanding_d;
        end else if (rspValid) begin
            if (stale_q != '0) begin
                stale_d = stale_q - CNT_W'(1);
            end else begin
                rspPc_d = rspPc_q + XLEN'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reqPc_q       <= RESET_PC;
            rspPc_q       <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            reqPc_q       <= reqPc_d;
            rspPc_q       <= rspPc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .push_i     (rspAccept),
        .pushData_i (pushEntry),
        .pop_i      (pop),
        .flush_i    (redirect),
        .headData_o (headEntry),
        .count_o    (fifoCount),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Credit accounting must never let a kept response hit a full queue,
    // and the memory must never answer a request that was not made.
    a_noOverflow : assert property (@(posedge i_clk) disable iff (i_rst)
        !(rspAccept && fifoFull && !pop));
    a_noSpuriousRsp : assert property (@(posedge i_clk) disable iff (i_rst)
        !(rspValid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit: a configurable-latency in-order memory model
// feeds the main instance; a second instance with RESET_PC near the top of the
// address space runs against a fixed 1-cycle memory to show PC wrap.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   memLat = 1;
    int   cyc = 0;

    logic [31:0] memAddrQ [$];
    int          memDueQ [$];
    logic        pend2 = 1'b0;
    logic [31:0] pend2Addr = '0;

    fetch_if #(.XLEN(32)) ifc ();
    fetch_if #(.XLEN(32)) ifc2 ();

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk (clock),
        .i_rst (reset),
        .bus   (ifc.master)
    );

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFFE)
    ) dutWrap (
        .i_clk (clock),
        .i_rst (reset),
        .bus   (ifc2.master)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Instruction contents the memory returns for a given word address.
    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    // Main memory model: responses are driven 1 time unit after the rising
    // edge of their due cycle; handshakes are sampled on the falling edge.
    always begin
        ifc.i_imem_rsp_valid = 1'b0;
        ifc.i_imem_rdata     = '0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (reset) begin
                memAddrQ.delete();
                memDueQ.delete();
                ifc.i_imem_rsp_valid = 1'b0;
            end else if (memDueQ.size() > 0 && memDueQ[0] == cyc) begin
                ifc.i_imem_rsp_valid = 1'b1;
                ifc.i_imem_rdata     = memData(memAddrQ[0]);
                void'(memAddrQ.pop_front());
                void'(memDueQ.pop_front());
            end else begin
                ifc.i_imem_rsp_valid = 1'b0;
            end
            @(negedge clock);
            if (!reset && ifc.o_imem_req_valid && ifc.i_imem_req_ready) begin
                memAddrQ.push_back(ifc.o_imem_addr);
                memDueQ.push_back(cyc + memLat);
            end
        end
    end

    // Second memory model: always answers one cycle after the request.
    always begin
        ifc2.i_imem_rsp_valid = 1'b0;
        ifc2.i_imem_rdata     = '0;
        forever begin
            @(posedge clock);
            #1;
            ifc2.i_imem_rsp_valid = pend2 && !reset;
            ifc2.i_imem_rdata     = memData(pend2Addr);
            pend2 = 1'b0;
            @(negedge clock);
            if (!reset && ifc2.o_imem_req_valid && ifc2.i_imem_req_ready) begin
                pend2     = 1'b1;
                pend2Addr = ifc2.o_imem_addr;
            end
        end
    end

    // Move to the next cycle; inputs changed here settle before sampling.
    task automatic nextCycle();
        @(posedge clock);
        #2;
    endtask

    // Hold reset for two edges and release it 2 units into "cycle 0".
    task automatic applyReset();
        reset = 1'b1;
        ifc.i_redirect_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (ifc.o_fetch_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_fetch_valid got=%b exp=0", ifc.o_fetch_valid);
        end
        checks++;
        if (ifc.o_imem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_addr got=%h exp=00000000", ifc.o_imem_addr);
        end
        checks++;
        if (ifc.o_imem_req_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_req_valid got=%b exp=1", ifc.o_imem_req_valid);
        end
        checks++;
        if (ifc2.o_imem_addr !== 32'hFFFF_FFFE) begin
            failures++;
            $display("[TB] FAIL reset_wrap_addr got=%h exp=fffffffe", ifc2.o_imem_addr);
        end
    endtask

    // 1-cycle memory, decode always ready: PCs stream out from cycle 2.
    task automatic test_streaming();
        logic [31:0] expPc;
        logic [31:0] expWrap;
        memLat = 1;
        ifc.i_dec_ready = 1'b1;
        applyReset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) nextCycle();
            @(negedge clock);
            checks++;
            if (ifc.o_imem_req_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stream_req_valid c=%0d got=%b exp=1", c, ifc.o_imem_req_valid);
            end
            if (c < 2) begin
                checks++;
                if (ifc.o_fetch_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stream_early_valid c=%0d got=%b exp=0", c, ifc.o_fetch_valid);
                end
            end else begin
                expPc = 32'(c - 2);
                checks++;
                if (ifc.o_fetch_valid !== 1'b1 || ifc.o_fetch_pc !== expPc ||
                    ifc.o_fetch_instr !== memData(expPc)) begin
                    failures++;
                    $display("[TB] FAIL stream_head c=%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                             c, ifc.o_fetch_valid, ifc.o_fetch_pc, ifc.o_fetch_instr,
                             expPc, memData(expPc));
                end
            end
            if (c >= 2 && c <= 4) begin
                expWrap = 32'hFFFF_FFFE + 32'(c - 2);
                checks++;
                if (ifc2.o_fetch_valid !== 1'b1 || ifc2.o_fetch_pc !== expWrap ||
                    ifc2.o_fetch_instr !== memData(expWrap)) begin
                    failures++;
                    $display("[TB] FAIL wrap_head c=%0d got v=%b pc=%h exp v=1 pc=%h",
                             c, ifc2.o_fetch_valid, ifc2.o_fetch_pc, expWrap);
                end
            end
        end
    endtask

    // Decode stalled: exactly DEPTH requests go out, then the queue drains in order.
    task automatic test_stall_drain();
        int reqCount;
        memLat = 1;
        ifc.i_dec_ready = 1'b0;
        reqCount = 0;
        applyReset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) nextCycle();
            @(negedge clock);
            if (ifc.o_imem_req_valid && ifc.i_imem_req_ready) reqCount++;
            if (c >= 4) begin
                checks++;
                if (ifc.o_imem_req_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_req_valid c=%0d got=%b exp=0", c, ifc.o_imem_req_valid);
                end
            end
        end
        checks++;
        if (reqCount != 4) begin
            failures++;
            $display("[TB] FAIL stall_req_count got=%0d exp=4", reqCount);
        end
        nextCycle();
        ifc.i_dec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nextCycle();
            @(negedge clock);
            checks++;
            if (ifc.o_fetch_valid !== 1'b1 || ifc.o_fetch_pc !== 32'(k) ||
                ifc.o_fetch_instr !== memData(32'(k))) begin
                failures++;
                $display("[TB] FAIL drain_head k=%0d got v=%b pc=%h exp v=1 pc=%h",
                         k, ifc.o_fetch_valid, ifc.o_fetch_pc, 32'(k));
            end
        end
    endtask

    // Redirect to 0x100 with three requests in flight at latency 3.
    task automatic test_redirect();
        memLat = 3;
        ifc.i_dec_ready = 1'b1;
        applyReset();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) nextCycle();
            @(negedge clock);
        end
        nextCycle();
        ifc.i_redirect_valid = 1'b1;
        ifc.i_redirect_pc    = 32'h100;
        @(negedge clock);
        checks++;
        if (dut.outstanding_q !== 3'd3) begin
            failures++;
            $display("[TB] FAIL redir_outstanding got=%0d exp=3", dut.outstanding_q);
        end
        checks++;
        if (ifc.o_imem_req_valid !== 1'b0 || ifc.o_fetch_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL redir_cycle_outputs got req=%b fv=%b exp req=0 fv=0",
                     ifc.o_imem_req_valid, ifc.o_fetch_valid);
        end
        nextCycle();
        ifc.i_redirect_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (dut.stale_q !== 3'd2) begin
            failures++;
            $display("[TB] FAIL redir_stale got=%0d exp=2", dut.stale_q);
        end
        checks++;
        if (ifc.o_imem_req_valid !== 1'b1 || ifc.o_imem_addr !== 32'h100) begin
            failures++;
            $display("[TB] FAIL redir_first_req got v=%b a=%h exp v=1 a=00000100",
                     ifc.o_imem_req_valid, ifc.o_imem_addr);
        end
        for (int c = 5; c < 8; c++) begin
            nextCycle();
            @(negedge clock);
            checks++;
            if (ifc.o_fetch_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL redir_drop c=%0d got fv=%b pc=%h exp fv=0",
                         c, ifc.o_fetch_valid, ifc.o_fetch_pc);
            end
        end
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            @(negedge clock);
            checks++;
            if (ifc.o_fetch_valid !== 1'b1 || ifc.o_fetch_pc !== 32'h100 + 32'(k) ||
                ifc.o_fetch_instr !== memData(32'h100 + 32'(k))) begin
                failures++;
                $display("[TB] FAIL redir_head k=%0d got v=%b pc=%h exp v=1 pc=%h",
                         k, ifc.o_fetch_valid, ifc.o_fetch_pc, 32'h100 + 32'(k));
            end
        end
    endtask

    // Redirect coinciding with a response and a decode-ready head (latency 2).
    task automatic test_redirect_rsp_pop();
        memLat = 2;
        ifc.i_dec_ready = 1'b1;
        applyReset();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) nextCycle();
            @(negedge clock);
        end
        checks++;
        if (ifc.o_fetch_valid !== 1'b1 || ifc.o_fetch_pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rp_pre_head got v=%b pc=%h exp v=1 pc=00000000",
                     ifc.o_fetch_valid, ifc.o_fetch_pc);
        end
        nextCycle();
        ifc.i_redirect_valid = 1'b1;
        ifc.i_redirect_pc    = 32'h200;
        @(negedge clock);
        checks++;
        if (ifc.o_fetch_valid !== 1'b0 || ifc.o_imem_req_valid !== 1'b0 ||
            dut.outstanding_q !== 3'd2) begin
            failures++;
            $display("[TB] FAIL rp_redir_cycle got fv=%b rv=%b out=%0d exp fv=0 rv=0 out=2",
                     ifc.o_fetch_valid, ifc.o_imem_req_valid, dut.outstanding_q);
        end
        nextCycle();
        ifc.i_redirect_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (ifc.o_fetch_valid !== 1'b0 || dut.stale_q !== 3'd1 || dut.outstanding_q !== 3'd1) begin
            failures++;
            $display("[TB] FAIL rp_after got fv=%b stale=%0d out=%0d exp fv=0 stale=1 out=1",
                     ifc.o_fetch_valid, dut.stale_q, dut.outstanding_q);
        end
        checks++;
        if (ifc.o_imem_req_valid !== 1'b1 || ifc.o_imem_addr !== 32'h200) begin
            failures++;
            $display("[TB] FAIL rp_first_req got v=%b a=%h exp v=1 a=00000200",
                     ifc.o_imem_req_valid, ifc.o_imem_addr);
        end
        nextCycle();
        @(negedge clock);
        checks++;
        if (dut.stale_q !== 3'd0 || ifc.o_fetch_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rp_stale_drained got stale=%0d fv=%b exp stale=0 fv=0",
                     dut.stale_q, ifc.o_fetch_valid);
        end
        nextCycle();
        @(negedge clock);
        checks++;
        if (ifc.o_fetch_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rp_gap got fv=%b exp fv=0", ifc.o_fetch_valid);
        end
        nextCycle();
        @(negedge clock);
        checks++;
        if (ifc.o_fetch_valid !== 1'b1 || ifc.o_fetch_pc !== 32'h200 ||
            ifc.o_fetch_instr !== memData(32'h200)) begin
            failures++;
            $display("[TB] FAIL rp_new_head got v=%b pc=%h i=%h exp v=1 pc=00000200 i=%h",
                     ifc.o_fetch_valid, ifc.o_fetch_pc, ifc.o_fetch_instr, memData(32'h200));
        end
    endtask

    // Reset asserted mid-cycle with entries queued and requests in flight.
    task automatic test_async_reset();
        memLat = 3;
        ifc.i_dec_ready = 1'b0;
        applyReset();
        for (int c = 1; c < 6; c++) nextCycle();
        checks++;
        if (ifc.o_fetch_valid !== 1'b1 || ifc.o_fetch_pc !== 32'h0 ||
            ifc.o_imem_req_valid !== 1'b0 || dut.outstanding_q !== 3'd2) begin
            failures++;
            $display("[TB] FAIL ar_pre got fv=%b pc=%h rv=%b out=%0d exp fv=1 pc=00000000 rv=0 out=2",
                     ifc.o_fetch_valid, ifc.o_fetch_pc, ifc.o_imem_req_valid, dut.outstanding_q);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ifc.o_fetch_valid !== 1'b0 || ifc.o_imem_req_valid !== 1'b1 ||
            ifc.o_imem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL ar_outputs got fv=%b rv=%b a=%h exp fv=0 rv=1 a=00000000",
                     ifc.o_fetch_valid, ifc.o_imem_req_valid, ifc.o_imem_addr);
        end
        checks++;
        if (dut.outstanding_q !== 3'd0 || dut.stale_q !== 3'd0) begin
            failures++;
            $display("[TB] FAIL ar_state got out=%0d stale=%0d exp 0 0",
                     dut.outstanding_q, dut.stale_q);
        end
        checks++;
        if (ifc2.o_fetch_valid !== 1'b0 || ifc2.o_imem_addr !== 32'hFFFF_FFFE) begin
            failures++;
            $display("[TB] FAIL ar_wrap got fv=%b a=%h exp fv=0 a=fffffffe",
                     ifc2.o_fetch_valid, ifc2.o_imem_addr);
        end
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Test sequence.
    initial begin
        ifc.i_imem_req_ready  = 1'b1;
        ifc.i_redirect_valid  = 1'b0;
        ifc.i_redirect_pc     = '0;
        ifc.i_dec_ready       = 1'b1;
        ifc2.i_imem_req_ready = 1'b1;
        ifc2.i_redirect_valid = 1'b0;
        ifc2.i_redirect_pc    = '0;
        ifc2.i_dec_ready      = 1'b1;

        test_reset();
        test_streaming();
        test_stall_drain();
        test_redirect();
        test_redirect_rsp_pop();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
